// File: rtl/alu_pkg.sv
// Shared encodings for the ALU host sequencer: opcodes, FSM states and byte-list sizing.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      DRIVE,
      WAIT_FIN,
      RESP
   } seq_state_e;

   localparam logic [1:0] BYTES_SHORT = 2'd2;
   localparam logic [1:0] BYTES_DIV   = 2'd3;

   function automatic logic [1:0] num_bytes_of(input logic [1:0] op);
      return (op == OP_DIV) ? BYTES_DIV : BYTES_SHORT;
   endfunction

   // Every byte is held for two beats except B1, so the last beat index is 2N-2.
   function automatic logic [2:0] last_beat_of(input logic [1:0] n);
      return {n, 1'b0} - 3'd2;
   endfunction

endpackage

// File: rtl/alu_byte_serializer.sv
// Walks the latched byte list onto the ALU inbus, one beat per cycle while active.
module alu_byte_serializer
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            active,
   input  logic [2:0][7:0] byte_list,
   input  logic [1:0]      num_bytes,
   output logic            start,
   output logic [7:0]      inbus,
   output logic            done
);

   logic [2:0] beat_reg;
   logic [2:0] last_beat;
   logic [1:0] sel;

   assign last_beat = last_beat_of(num_bytes);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_reg <= '0;
      end else if (active && !done) begin
         beat_reg <= beat_reg + 3'd1;
      end else begin
         beat_reg <= '0;
      end
   end

   // Beat-to-byte map: B0 on beats 0-1, B1 on beat 2, B2 on beats 3-4.
   always_comb begin
      sel = 2'd2;
      case (beat_reg)
         3'd0, 3'd1: sel = 2'd0;
         3'd2:       sel = 2'd1;
         default:    sel = 2'd2;
      endcase
   end

   assign start = active && (beat_reg == 3'd0);
   assign inbus = active ? byte_list[sel] : 8'h00;
   assign done  = active && (beat_reg == last_beat);

endmodule

// File: rtl/alu_host_sequencer.sv
// Host-side sequencer for the serial ALU: accepts a request, drives operand beats,
// waits for final (with timeout) and holds the response until the host takes it.
module alu_host_sequencer
   import alu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMR_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [7:0]  req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic        rsp_timeout,
   output logic [1:0]  alu_op,
   output logic        alu_start,
   output logic [7:0]  alu_inbus,
   input  logic        alu_ready,
   input  logic        alu_final,
   input  logic [15:0] alu_outbus
);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   seq_state_e       state_reg, state_next;
   logic [TMR_W-1:0] timer_reg, timer_next;
   logic [1:0]       op_reg;
   logic [2:0][7:0]  bytes_reg;
   logic [1:0]       nbytes_reg;
   logic [15:0]      result_reg;
   logic             timeout_reg;
   logic             accept, capture, abort;
   logic             ser_start, ser_done;
   logic [7:0]       ser_inbus;
   logic [7:0]       last_byte;

   assign accept = (state_reg == IDLE) && req_valid;

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      capture    = 1'b0;
      abort      = 1'b0;
      case (state_reg)
         IDLE: begin
            timer_next = '0;
            if (req_valid) state_next = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (alu_ready) begin
               state_next = DRIVE;
               timer_next = '0;
            end else if (timer_reg == TMR_LAST) begin
               abort      = 1'b1;
               state_next = RESP;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         DRIVE: begin
            if (ser_done) begin
               state_next = WAIT_FIN;
               timer_next = '0;
            end
         end
         WAIT_FIN: begin
            // final is checked first so it wins over a coincident expiry
            if (alu_final) begin
               capture    = 1'b1;
               state_next = RESP;
            end else if (timer_reg == TMR_LAST) begin
               abort      = 1'b1;
               state_next = RESP;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         timer_reg   <= '0;
         op_reg      <= '0;
         bytes_reg   <= '0;
         nbytes_reg  <= '0;
         result_reg  <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         if (accept) begin
            op_reg     <= req_op;
            nbytes_reg <= num_bytes_of(req_op);
            if (req_op == OP_DIV) bytes_reg <= {req_b, req_a[7:0], req_a[15:8]};
            else                  bytes_reg <= {8'h00, req_b, req_a[7:0]};
         end
         if (capture) begin
            result_reg  <= alu_outbus;
            timeout_reg <= 1'b0;
         end else if (abort) begin
            result_reg  <= '0;
            timeout_reg <= 1'b1;
         end
      end
   end

   alu_byte_serializer u_serializer (
      .clk       (clk),
      .rst       (rst),
      .active    (state_reg == DRIVE),
      .byte_list (bytes_reg),
      .num_bytes (nbytes_reg),
      .start     (ser_start),
      .inbus     (ser_inbus),
      .done      (ser_done)
   );

   assign last_byte   = bytes_reg[nbytes_reg - 2'd1];
   assign req_ready   = (state_reg == IDLE) && !rst;
   assign alu_op      = (state_reg == IDLE) ? 2'b00 : op_reg;
   assign alu_start   = ser_start;
   assign alu_inbus   = (state_reg == DRIVE) ? ser_inbus :
                        ((state_reg == WAIT_FIN) || (state_reg == RESP)) ? last_byte : 8'h00;
   assign rsp_valid   = (state_reg == RESP);
   assign rsp_result  = rsp_valid ? result_reg : 16'h0000;
   assign rsp_timeout = rsp_valid && timeout_reg;

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Directed bench for alu_host_sequencer with a behavioural serial ALU and a response scoreboard.
module tb_alu_host_sequencer;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [15:0] req_a = 16'h0000;
   logic [7:0]  req_b = 8'h00;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_result;
   logic        rsp_timeout;
   logic [1:0]  alu_op;
   logic        alu_start;
   logic [7:0]  alu_inbus;
   logic        alu_ready = 1'b1;
   logic        alu_final = 1'b0;
   logic [15:0] alu_outbus = 16'h0000;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // scoreboard and ALU model knobs
   logic [15:0] exp_res[$];
   bit          exp_tmo[$];
   logic [7:0]  exp_seq[$];
   logic [1:0]  cur_op = 2'b00;
   bit          hold_final = 1'b0;
   int          fin_delay = 0;
   int          start_cnt = 0;
   int          last_beat_cyc = 0;

   alu_host_sequencer #(.TIMEOUT_CYCLES(TMO), .TMR_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_timeout (rsp_timeout),
      .alu_op      (alu_op),
      .alu_start   (alu_start),
      .alu_inbus   (alu_inbus),
      .alu_ready   (alu_ready),
      .alu_final   (alu_final),
      .alu_outbus  (alu_outbus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural ALU: gathers the beats after start, computes, and raises final.
   logic [7:0]  seq[$];
   bit          collecting = 1'b0;
   int          beats_need = 0;
   int          fin_wait = -1;
   int          fin_hold = 0;
   logic [7:0]  mb0, mb1, mb2, msum;
   logic [15:0] mdvd, model_res;

   always @(negedge clk) begin
      if (rst) begin
         collecting = 1'b0;
         fin_wait   = -1;
         fin_hold   = 0;
         seq.delete();
         alu_final <= 1'b0;
      end else begin
         if (fin_hold > 0) begin
            fin_hold--;
            if (fin_hold == 0) alu_final <= 1'b0;
         end
         if (fin_wait == 0) begin
            alu_final  <= 1'b1;
            alu_outbus <= model_res;
            fin_hold   = 2;
            fin_wait   = -1;
         end else if (fin_wait > 0) begin
            fin_wait--;
         end
         if (alu_start) begin
            start_cnt++;
            seq.delete();
            seq.push_back(alu_inbus);
            collecting = 1'b1;
            beats_need = (alu_op == 2'b11) ? 5 : 3;
         end else if (collecting) begin
            seq.push_back(alu_inbus);
         end
         if (collecting && seq.size() == beats_need) begin
            collecting    = 1'b0;
            last_beat_cyc = cyc;
            chk("inbus_len", seq.size(), exp_seq.size());
            for (int i = 0; i < seq.size() && i < exp_seq.size(); i++)
               chk($sformatf("inbus_beat%0d", i), seq[i], exp_seq[i]);
            mb0 = seq[0];
            mb1 = seq[2];
            mb2 = (beats_need == 5) ? seq[4] : 8'h00;
            case (alu_op)
               2'b00: begin msum = mb0 + mb1; model_res = {msum, 8'h00}; end
               2'b01: begin msum = mb1 - mb0; model_res = {msum, 8'h00}; end
               2'b10: model_res = 16'(mb0 * mb1);
               default: begin
                  mdvd = {mb0, mb1};
                  if (mb2 == 8'h00) model_res = 16'hFFFF;
                  else model_res = {8'(mdvd % 16'(mb2)), 8'(mdvd / 16'(mb2))};
               end
            endcase
            if (!hold_final) begin
               if (fin_delay == 0) begin
                  alu_final  <= 1'b1;
                  alu_outbus <= model_res;
                  fin_hold   = 2;
               end else begin
                  fin_wait = fin_delay - 1;
               end
            end
         end
      end
   end

   // Per-cycle comparison of the response side against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (alu_start) chk("alu_op_at_start", alu_op, cur_op);
         if (rsp_valid) begin
            if (exp_res.size() == 0) begin
               chk("spurious_rsp", rsp_valid, 0);
            end else begin
               chk("rsp_result", rsp_result, exp_res[0]);
               chk("rsp_timeout", rsp_timeout, exp_tmo[0]);
               chk("req_ready_in_rsp", req_ready, 0);
               if (rsp_ready) begin
                  void'(exp_res.pop_front());
                  void'(exp_tmo.pop_front());
               end
            end
         end
      end
   end

   task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] exp_r, input bit exp_t, input int fdly, input int hold,
                         output int acc_cyc, output int rsp_cyc);
      int n;
      logic [15:0] r0;
      bit stable;
      start_cnt = 0;
      cur_op    = op;
      fin_delay = fdly;
      exp_seq.delete();
      if (op == 2'b11) begin
         exp_seq.push_back(a[15:8]); exp_seq.push_back(a[15:8]);
         exp_seq.push_back(a[7:0]);  exp_seq.push_back(b); exp_seq.push_back(b);
      end else begin
         exp_seq.push_back(a[7:0]); exp_seq.push_back(a[7:0]); exp_seq.push_back(b);
      end
      exp_res.push_back(exp_r);
      exp_tmo.push_back(exp_t);
      @(posedge clk); #1;
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      chk("req_accept", req_ready, 1);
      @(posedge clk); #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
      chk("rsp_arrives", rsp_valid, 1);
      rsp_cyc = cyc;
      stable  = 1'b1;
      r0      = rsp_result;
      repeat (hold) begin
         @(negedge clk);
         if (!rsp_valid || rsp_result !== r0 || req_ready) stable = 1'b0;
      end
      if (hold > 0) chk("rsp_stable_backpressure", stable, 1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_rsp", {rsp_valid, req_ready}, 2'b01);
      chk("start_pulses", start_cnt, alu_ready ? 1 : 0);
   endtask

   initial begin
      int ac, rc, n;
      #1 rst = 1'b1;
      #1 chk("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_timeout, alu_op, alu_start, alu_inbus}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);

      run_op(2'b00, 16'd20, 8'd10, 16'h1E00, 1'b0, 3, 0, ac, rc);       // add
      run_op(2'b01, 16'd10, 8'd30, 16'h1400, 1'b0, 0, 10, ac, rc);      // sub, final on entry, back-pressure
      run_op(2'b10, 16'd5, 8'd4, 16'h0014, 1'b0, 2, 0, ac, rc);         // mul
      run_op(2'b11, 16'h03E8, 8'd12, 16'h0453, 1'b0, 4, 0, ac, rc);     // div
      run_op(2'b00, 16'hAB10, 8'h01, 16'h1100, 1'b0, 1, 0, ac, rc);     // upper A ignored

      hold_final = 1'b1;
      run_op(2'b10, 16'd5, 8'd4, 16'h0000, 1'b1, 0, 0, ac, rc);
      chk("fin_timeout_latency", rc - last_beat_cyc, TMO + 1);
      hold_final = 1'b0;

      alu_ready = 1'b0;
      run_op(2'b00, 16'd1, 8'd2, 16'h0000, 1'b1, 0, 0, ac, rc);
      chk("rdy_timeout_latency", rc - ac, TMO);
      alu_ready = 1'b1;

      // reset in the middle of the operand beats
      cur_op = 2'b11;
      exp_seq.delete();
      @(posedge clk); #1;
      req_op = 2'b11; req_a = 16'h1234; req_b = 8'h05; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!alu_start && n < 50) begin @(negedge clk); n++; end
      chk("start_before_reset", alu_start, 1);
      @(posedge clk); #2 rst = 1'b1;
      #1 chk("reset_mid_drive", {req_ready, rsp_valid, rsp_result, rsp_timeout, alu_op, alu_start, alu_inbus}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_op(2'b11, 16'h0064, 8'd7, 16'h020E, 1'b0, 2, 0, ac, rc);      // 100/7 = 14 r 2
      chk("scoreboard_drained", exp_res.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_host_sequencer.md
Name: alu_host_sequencer

Overview:
Initiator-side controller that drives the serial operand protocol of the 8-bit ALU core (alu_top). It accepts one complete operation request on a parallel valid/ready interface and waits for the ALU's ready. It then serialises the operands byte by byte onto the ALU inbus with a start pulse, waits for final, and returns the captured 16-bit outbus on a valid/ready response interface. It sits between a host (CPU/UART bridge) and alu_top.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waited in WAIT_RDY or WAIT_FIN before aborting with timeout
TMR_W, 8, width of timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  host request valid
req_ready  out  1  high only in IDLE with rst low; a request is accepted when req_valid && req_ready
req_op  in  2  00 add, 01 sub, 10 mul, 11 div
req_a  in  16  operand A; only [7:0] used for op 00/01/10; full 16-bit dividend for op 11
req_b  in  8  operand B / divisor
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_result  out  16  captured alu_outbus; 0 on timeout
rsp_timeout  out  1  response is a timeout abort
alu_op  out  2  op to ALU, held from accept through RESP
alu_start  out  1  one-cycle start pulse
alu_inbus  out  8  operand byte
alu_ready  in  1  ALU idle/ready
alu_final  in  1  ALU result valid
alu_outbus  in  16  ALU result

Behaviour:
- Reset (async, immediate): state IDLE; timer and beat counter 0; every output 0, including req_ready while rst is high; operand and result registers cleared. Reset mid-operation abandons the transfer with no response.
- Accept in IDLE: latch op and operands; build byte list.
  - op 00/01/10: B0=req_a[7:0], B1=req_b, N=2.
  - op 11: B0=req_a[15:8], B1=req_a[7:0], B2=req_b, N=3.
  - Next state WAIT_RDY; alu_op is driven from the next cycle.
- WAIT_RDY: wait for alu_ready=1, then go to DRIVE on the next edge. The timer increments each cycle; reaching TIMEOUT_CYCLES goes to RESP with timeout.
- DRIVE, beat schedule with beat counter k from 0:
  - k=0: alu_start=1, alu_inbus=B0.
  - k=1: start=0, inbus=B0 (hold).
  - k=2: inbus=B1.
  - op 11 only: k=3 inbus=B2, k=4 inbus=B2.
  - Last beat is k=2 for N=2 and k=4 for N=3; then go to WAIT_FIN with the timer cleared.
  - alu_start is high for exactly one cycle per operation.
- WAIT_FIN: alu_inbus holds the last byte.
  - On the first cycle alu_final=1: capture alu_outbus into rsp_result, rsp_timeout=0, go to RESP.
  - The timer increments otherwise; at TIMEOUT_CYCLES go to RESP with rsp_result=0, rsp_timeout=1.
  - alu_final already high on WAIT_FIN entry is accepted.
- RESP: rsp_valid=1 with rsp_result and rsp_timeout stable until rsp_ready=1, then IDLE on that edge. In IDLE, alu_inbus and alu_op return to 0.
- Simultaneous events:
  - alu_final and timer expiry on the same cycle: final wins.
  - rsp_ready held high: back-to-back requests are possible; minimum one IDLE cycle between responses.
- No arithmetic is performed; rsp_result is a raw copy of alu_outbus.
  - add/sub result is in [15:8].
  - mul result is the full 16 bits.
  - div: remainder in [15:8], quotient in [7:0].

Decomposition:
- Shared package alu_pkg: op encodings (OP_ADD=00, OP_SUB=01, OP_MUL=10, OP_DIV=11), state encoding (IDLE, WAIT_RDY, DRIVE, WAIT_FIN, RESP), per-op beat counts.
- One natural sub-module: alu_byte_serializer, which takes the byte list plus N and produces start/inbus per beat with a done flag.
- FSM, timer and response registers stay in the top.

Test Plan:
The bench uses alu_top or a behavioural ALU model.
- add: req_op=00, a=20, b=10 -> alu_start single pulse with inbus=20, then 20, then 10; rsp_result[15:8]=30, rsp_timeout=0.
- sub: op=01, a=10, b=30 -> rsp_result[15:8]=20 (b-a).
- mul: op=10, a=5, b=4 -> rsp_result=16'h0014.
- div: op=11, a=16'h03E8, b=12 -> inbus sequence 03,03,E8,0C,0C; rsp_result=16'h0453 (R=4, Q=83).
- Timeout: model holds alu_final=0 -> rsp_valid with rsp_timeout=1, rsp_result=0 exactly TIMEOUT_CYCLES cycles after WAIT_FIN entry. Repeat with alu_ready stuck low to cover WAIT_RDY.
- Back-pressure and reset: with rsp_ready=0 for 10 cycles, response stays stable and req_ready=0. Asserting rst during DRIVE forces all outputs 0 immediately and a new request completes normally.
